// File: rtl/sort_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sort_sequencer
// Brief    : In-place ascending bubble sort of signed doublewords in data
//            memory, using the shared core ALU for every compare.
// Revision : 1.0
// ============================================================================
module sort_sequencer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_count,
    output logic              o_busy,
    output logic              o_done,
    output logic [15:0]       o_swap_count,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd_en,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_wr_en,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_alu_req,
    input  logic              i_alu_gnt,
    output logic [3:0]        o_alu_op,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    input  logic [DATA_W-1:0] i_alu_result
);

    localparam logic [3:0] c_OP_SUB = 4'b0110;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_CAP  = 3'd3,
        S_CMP  = 3'd4,
        S_WR0  = 3'd5,
        S_WR1  = 3'd6,
        S_FIN  = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_base;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_i;
    logic [CNT_W-1:0]   r_j;
    logic [DATA_W-1:0]  r_ea;
    logic [DATA_W-1:0]  r_eb;
    logic               r_swapped;
    logic [15:0]        r_swap_count;
    logic               r_busy;
    logic               r_done;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_rd_en;
    logic               r_mem_wr_en;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_alu_req;
    logic [3:0]         r_alu_op;
    logic [DATA_W-1:0]  r_alu_a;
    logic [DATA_W-1:0]  r_alu_b;

    logic [ADDR_W-1:0]  w_base_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_i_nxt;
    logic [CNT_W-1:0]   w_j_nxt;
    logic               w_swapped_nxt;
    logic [15:0]        w_swap_count_nxt;
    logic               w_advance;
    logic [CNT_W:0]     w_j_inc;
    logic [CNT_W:0]     w_i_inc;
    logic [CNT_W:0]     w_cnt_m1;
    logic [CNT_W:0]     w_pass_len;
    logic               w_addr_upd;
    logic               w_addr_hi;
    logic [ADDR_W-1:0]  w_addr_nxt;

    // One-wider arithmetic keeps the pass-limit compare free of wraparound.
    assign w_j_inc    = {1'b0, r_j} + (CNT_W+1)'(1);
    assign w_i_inc    = {1'b0, r_i} + (CNT_W+1)'(1);
    assign w_cnt_m1   = {1'b0, r_cnt} - (CNT_W+1)'(1);
    assign w_pass_len = w_cnt_m1 - {1'b0, r_i};

    always_comb begin
        w_state_nxt      = r_state;
        w_base_nxt       = r_base;
        w_cnt_nxt        = r_cnt;
        w_i_nxt          = r_i;
        w_j_nxt          = r_j;
        w_swapped_nxt    = r_swapped;
        w_swap_count_nxt = r_swap_count;
        w_advance        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_count < CNT_W'(2)) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_base_nxt       = i_base_addr;
                        w_cnt_nxt        = i_count;
                        w_i_nxt          = '0;
                        w_j_nxt          = '0;
                        w_swapped_nxt    = 1'b0;
                        w_swap_count_nxt = '0;
                        w_state_nxt      = S_RD0;
                    end
                end
            end
            S_RD0: w_state_nxt = S_RD1;
            S_RD1: w_state_nxt = S_CAP;
            S_CAP: w_state_nxt = S_CMP;
            S_CMP: begin
                if (i_alu_gnt) begin
                    // eb - ea negative means the pair is out of order.
                    if (i_alu_result[DATA_W-1]) begin
                        w_swapped_nxt = 1'b1;
                        if (r_swap_count != 16'hFFFF) begin
                            w_swap_count_nxt = r_swap_count + 16'd1;
                        end
                        w_state_nxt = S_WR0;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            S_WR0: w_state_nxt = S_WR1;
            S_WR1: w_advance = 1'b1;
            S_FIN: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_advance) begin
            if (w_j_inc < w_pass_len) begin
                w_j_nxt     = w_j_inc[CNT_W-1:0];
                w_state_nxt = S_RD0;
            end else if (!r_swapped || (w_i_inc == w_cnt_m1)) begin
                w_state_nxt = S_FIN;
            end else begin
                w_i_nxt       = w_i_inc[CNT_W-1:0];
                w_j_nxt       = '0;
                w_swapped_nxt = 1'b0;
                w_state_nxt   = S_RD0;
            end
        end
    end

    // Outputs are registered from the next state so strobes line up with it.
    assign w_addr_upd = (w_state_nxt == S_RD0) || (w_state_nxt == S_RD1) ||
                        (w_state_nxt == S_WR0) || (w_state_nxt == S_WR1);
    assign w_addr_hi  = (w_state_nxt == S_RD1) || (w_state_nxt == S_WR1);
    assign w_addr_nxt = w_base_nxt + (ADDR_W'(w_j_nxt) << 3) +
                        (w_addr_hi ? ADDR_W'(8) : ADDR_W'(0));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_base       <= '0;
            r_cnt        <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_ea         <= '0;
            r_eb         <= '0;
            r_swapped    <= 1'b0;
            r_swap_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_rd_en  <= 1'b0;
            r_mem_wr_en  <= 1'b0;
            r_mem_wdata  <= '0;
            r_alu_req    <= 1'b0;
            r_alu_op     <= 4'b0000;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
        end else begin
            r_base       <= w_base_nxt;
            r_cnt        <= w_cnt_nxt;
            r_i          <= w_i_nxt;
            r_j          <= w_j_nxt;
            r_swapped    <= w_swapped_nxt;
            r_swap_count <= w_swap_count_nxt;
            if (r_state == S_RD1) begin
                r_ea <= i_mem_rdata;
            end
            if (r_state == S_CAP) begin
                r_eb    <= i_mem_rdata;
                r_alu_a <= i_mem_rdata;
                r_alu_b <= r_ea;
            end
            r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
            r_done      <= (w_state_nxt == S_FIN);
            r_mem_rd_en <= (w_state_nxt == S_RD0) || (w_state_nxt == S_RD1);
            r_mem_wr_en <= (w_state_nxt == S_WR0) || (w_state_nxt == S_WR1);
            if (w_addr_upd) begin
                r_mem_addr <= w_addr_nxt;
            end
            if (w_state_nxt == S_WR0) begin
                r_mem_wdata <= r_eb;
            end else if (w_state_nxt == S_WR1) begin
                r_mem_wdata <= r_ea;
            end
            r_alu_req <= (w_state_nxt == S_CMP);
            r_alu_op  <= (w_state_nxt == S_CMP) ? c_OP_SUB : 4'b0000;
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_swap_count = r_swap_count;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_rd_en  = r_mem_rd_en;
    assign o_mem_wr_en  = r_mem_wr_en;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_alu_req    = r_alu_req;
    assign o_alu_op     = r_alu_op;
    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;

endmodule
`default_nettype wire

// File: tb/tb_sort_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_sequencer
// Brief    : Self-checking bench for sort_sequencer against a queue-free
//            bubble-sort reference model and a behavioural memory/ALU.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sort_sequencer;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;
    localparam int CNT_W  = 8;
    localparam int LIMIT  = 20000;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [ADDR_W-1:0] i_base_addr;
    logic [CNT_W-1:0]  i_count;
    logic              o_busy;
    logic              o_done;
    logic [15:0]       o_swap_count;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_rd_en;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              o_mem_wr_en;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              o_alu_req;
    logic              i_alu_gnt;
    logic [3:0]        o_alu_op;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_b;
    logic [DATA_W-1:0] w_alu_result;

    logic [63:0] mem [0:255];
    longint      stim  [0:255];
    longint      ref_a [0:255];
    int          ref_cmp;
    int          ref_sw;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    assign w_alu_result = o_alu_a - o_alu_b;

    always @(posedge clk) begin
        if (o_mem_rd_en) r_mem_rdata <= mem[o_mem_addr[10:3]];
        if (o_mem_wr_en) mem[o_mem_addr[10:3]] <= o_mem_wdata;
    end

    sort_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_count      (i_count),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_swap_count (o_swap_count),
        .o_mem_addr   (o_mem_addr),
        .o_mem_rd_en  (o_mem_rd_en),
        .i_mem_rdata  (r_mem_rdata),
        .o_mem_wr_en  (o_mem_wr_en),
        .o_mem_wdata  (o_mem_wdata),
        .o_alu_req    (o_alu_req),
        .i_alu_gnt    (i_alu_gnt),
        .o_alu_op     (o_alu_op),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .i_alu_result (w_alu_result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Textbook bubble sort with early exit on a clean pass.
    task automatic ref_sort(input int n);
        longint t;
        bit     any;
        ref_cmp = 0;
        ref_sw  = 0;
        for (int p = 0; p < n - 1; p++) begin
            any = 1'b0;
            for (int k = 0; k < n - 1 - p; k++) begin
                ref_cmp++;
                if (ref_a[k+1] < ref_a[k]) begin
                    t = ref_a[k]; ref_a[k] = ref_a[k+1]; ref_a[k+1] = t;
                    ref_sw++;
                    any = 1'b1;
                end
            end
            if (!any) break;
        end
    endtask

    // mode 0: grant tied high, 1: grant withheld 5 cycles in first compare,
    // 2: random grant, 3: random grant plus start/count/base noise while busy.
    task automatic run_sort(input string tag, input int n, input int bidx, input int mode);
        logic [ADDR_W-1:0] base;
        logic [63:0]       cap_a, cap_b;
        logic [3:0]        cap_op;
        int cyc, rd_cnt, wr_cnt, stalls, busy_err, ovl_err, addr_err, op_err;
        int held, hold_err;
        bit hold_seen, hold_done, timed_out;
        base = ADDR_W'(bidx * 8);
        for (int k = 0; k < n; k++) begin
            mem[bidx+k] = stim[k];
            ref_a[k]    = stim[k];
        end
        ref_sort(n);
        cyc = 0; rd_cnt = 0; wr_cnt = 0; stalls = 0; busy_err = 0; ovl_err = 0;
        addr_err = 0; op_err = 0; held = 0; hold_err = 0;
        hold_seen = 0; hold_done = 0; timed_out = 0;
        cap_a = '0; cap_b = '0; cap_op = '0;
        i_alu_gnt = (mode == 1) ? 1'b0 : 1'b1;
        @(negedge clk);
        i_start = 1'b1; i_base_addr = base; i_count = CNT_W'(n);
        @(posedge clk); #1;
        i_start = 1'b0;
        while (1) begin
            if (mode == 2 || mode == 3) i_alu_gnt = 1'($urandom_range(0, 1));
            if (mode == 1 && !hold_done) begin
                if (hold_seen && (!o_alu_req || o_alu_a !== cap_a || o_alu_b !== cap_b ||
                                  o_alu_op !== cap_op)) hold_err++;
                if (o_alu_req) begin
                    if (!hold_seen) begin
                        cap_a = o_alu_a; cap_b = o_alu_b; cap_op = o_alu_op; hold_seen = 1;
                    end
                    if (held < 5) begin
                        i_alu_gnt = 1'b0; held++;
                    end else begin
                        i_alu_gnt = 1'b1; hold_done = 1;
                    end
                end
            end
            if (o_mem_rd_en) rd_cnt++;
            if (o_mem_wr_en) wr_cnt++;
            if (o_mem_rd_en && o_mem_wr_en) ovl_err++;
            if ((o_mem_rd_en || o_mem_wr_en) &&
                (o_mem_addr < base || o_mem_addr >= base + 64'(8 * n) || o_mem_addr[2:0] != 3'd0))
                addr_err++;
            if (o_alu_req && o_alu_op !== 4'b0110) op_err++;
            if (o_alu_req && !i_alu_gnt) stalls++;
            if (o_done === o_busy) busy_err++;
            if (o_done) break;
            if (cyc >= LIMIT) begin timed_out = 1; break; end
            if (mode == 3) begin
                i_start     = ($urandom_range(0, 3) == 0);
                i_count     = CNT_W'($urandom);
                i_base_addr = {$urandom, $urandom};
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_start   = 1'b0;
        i_alu_gnt = 1'b1;
        check({tag, " timeout"},   64'(timed_out), 64'd0);
        check({tag, " cycles"},    64'(cyc), 64'(4 * ref_cmp + 2 * ref_sw + stalls));
        check({tag, " rd_strb"},   64'(rd_cnt), 64'(2 * ref_cmp));
        check({tag, " wr_strb"},   64'(wr_cnt), 64'(2 * ref_sw));
        check({tag, " swaps"},     64'(o_swap_count), 64'(n < 2 ? int'(o_swap_count) : ref_sw));
        check({tag, " busy"},      64'(busy_err), 64'd0);
        check({tag, " rd_wr_ovl"}, 64'(ovl_err + addr_err + op_err), 64'd0);
        if (mode == 1) begin
            check({tag, " held"},     64'(held), 64'd5);
            check({tag, " hold_val"}, 64'(hold_err), 64'd0);
        end
        for (int k = 0; k < n; k++)
            check($sformatf("%s mem[%0d]", tag, k), mem[bidx+k], 64'(ref_a[k]));
        @(posedge clk); #1;
        check({tag, " done_once"}, {63'd0, o_done}, 64'd0);
        check({tag, " idle_busy"}, {63'd0, o_busy}, 64'd0);
    endtask

    task automatic set4(input longint a, input longint b, input longint c, input longint d);
        stim[0] = a; stim[1] = b; stim[2] = c; stim[3] = d;
    endtask

    task automatic reset_mid_wr0();
        int w;
        bit hit;
        set4(4, 3, 2, 1);
        for (int k = 0; k < 4; k++) mem[32+k] = stim[k];
        i_alu_gnt = 1'b1;
        @(negedge clk);
        i_start = 1'b1; i_base_addr = 64'h100; i_count = 8'd4;
        @(posedge clk); #1;
        i_start = 1'b0;
        hit = 0;
        for (w = 0; w < 200; w++) begin
            if (o_mem_wr_en) begin hit = 1; break; end
            @(posedge clk); #1;
        end
        check("rst_wr0 reached", 64'(hit), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_wr0 busy",  {63'd0, o_busy}, 64'd0);
        check("rst_wr0 wr_en", {63'd0, o_mem_wr_en}, 64'd0);
        check("rst_wr0 swaps", 64'(o_swap_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_wr0 mem0", mem[32], 64'd4);
    endtask

    initial begin
        longint v;
        int     n, mode;
        rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_count = '0; i_alu_gnt = 1'b1;
        for (int k = 0; k < 256; k++) mem[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy",  {63'd0, o_busy}, 64'd0);
        check("rst done",  {63'd0, o_done}, 64'd0);
        check("rst rd_en", {63'd0, o_mem_rd_en}, 64'd0);
        check("rst wr_en", {63'd0, o_mem_wr_en}, 64'd0);
        check("rst req",   {63'd0, o_alu_req}, 64'd0);
        check("rst op",    {60'd0, o_alu_op}, 64'd0);
        check("rst addr",  o_mem_addr, 64'd0);
        check("rst wdata", o_mem_wdata, 64'd0);
        check("rst alu_a", o_alu_a, 64'd0);
        check("rst alu_b", o_alu_b, 64'd0);
        check("rst swaps", 64'(o_swap_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        set4(1, 2, 3, 4);     run_sort("sorted4", 4, 32, 0);
        set4(4, 3, 2, 1);     run_sort("rev4", 4, 32, 0);
        set4(5, -3, 0, -7); stim[4] = 2;
        run_sort("mixed5", 5, 32, 0);
        stim[0] = 9;          run_sort("cnt1", 1, 64, 0);
        run_sort("cnt0", 0, 64, 0);
        stim[0] = 2; stim[1] = 1;
        run_sort("cnt2", 2, 80, 0);
        set4(4, 3, 2, 1);     run_sort("stall", 4, 32, 1);
        reset_mid_wr0();
        set4(4, 3, 2, 1);     run_sort("after_rst", 4, 32, 0);

        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(2, 16);
            for (int k = 0; k < n; k++) begin
                if (t % 3 == 0) begin
                    v = longint'($urandom_range(0, 10)) - 5;
                end else begin
                    v = $signed({$urandom, $urandom});
                    v = v >>> 3;
                end
                stim[k] = v;
            end
            mode = (t % 3 == 0) ? 0 : ((t % 3 == 1) ? 2 : 3);
            run_sort($sformatf("rnd%0d", t), n, $urandom_range(0, 255 - n), mode);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sort_sequencer.md
Name: sort_sequencer

Overview:
- Hardware bubble-sort controller for the pipelined core.
- Sorts `count` signed 64-bit doublewords in data memory, ascending, in place, starting at `base_addr`.
- Shares the core ALU through a req/gnt handshake and issues every compare as an ALU subtract (Operation 4'b0110).
- `busy` drives the pipeline stall, so the sequencer owns the data-memory port while it runs.

Parameters:
- DATA_W, 64, element and ALU data width.
- ADDR_W, 64, byte address width.
- CNT_W, 8, width of the element count.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle start pulse, sampled only in IDLE
- base_addr  input  ADDR_W  byte address of element 0; stride is 8 bytes
- count  input  CNT_W  number of elements
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- swap_count  output  16  swaps performed in the last sort; holds until the next start
- mem_addr  output  ADDR_W  data-memory byte address
- mem_rd_en  output  1  read strobe; mem_rdata is valid the next cycle
- mem_rdata  input  DATA_W  read data
- mem_wr_en  output  1  write strobe; write commits at the clock edge
- mem_wdata  output  DATA_W  write data
- alu_req  output  1  ALU request
- alu_gnt  input  1  ALU grant
- alu_op  output  4  ALU Operation code
- alu_a  output  DATA_W  ALU operand A
- alu_b  output  DATA_W  ALU operand B
- alu_result  input  DATA_W  combinational ALU result (A-B)

Behaviour:
- Reset (asynchronous, any state) returns the FSM to IDLE.
  - Zeroed: busy, done, mem_rd_en, mem_wr_en, alu_req, mem_addr, mem_wdata, alu_a, alu_b, swap_count, and the i, j and swapped registers.
  - alu_op resets to 4'b0000.
  - A sort interrupted by reset leaves memory partially sorted; this is legal.
- Registers:
  - i: pass index.
  - j: compare index.
  - ea: element j.
  - eb: element j+1.
  - swapped: pass flag.
- States: IDLE, RD0, RD1, CAP, CMP, WR0, WR1, FIN.
- IDLE:
  - On start with count<2 -> FIN, with no memory or ALU activity.
  - On start with count≥2: latch base_addr and count, clear i, j, swapped and swap_count -> RD0.
- RD0: mem_addr=base+8*j, mem_rd_en=1 -> RD1.
- RD1: ea<=mem_rdata; mem_addr=base+8*(j+1), mem_rd_en=1 -> CAP.
- CAP: eb<=mem_rdata -> CMP.
- CMP:
  - Drive alu_req=1, alu_op=4'b0110, alu_a=eb, alu_b=ea.
  - Hold these values stable while alu_gnt=0.
  - In the cycle alu_gnt=1, the decision is swap = alu_result[DATA_W-1].
  - A two's-complement overflow of eb-ea is not corrected. This is defined behaviour; the bench uses operands with |x| < 2^62.
  - swap=1: set swapped, increment swap_count (saturating at 16'hFFFF) -> WR0.
  - swap=0 -> advance.
- WR0: mem_addr=base+8*j, mem_wdata=eb, mem_wr_en=1 -> WR1.
- WR1: mem_addr=base+8*(j+1), mem_wdata=ea, mem_wr_en=1 -> advance.
- Advance:
  - If j+1 < count-1-i: j<=j+1 -> RD0.
  - Else (end of pass):
    - If swapped=0 or i+1 = count-1 -> FIN.
    - Otherwise i<=i+1, j<=0, swapped<=0 -> RD0.
- FIN: done=1 for exactly one cycle, busy=0 -> IDLE.
- busy is 1 in RD0..WR1 and 0 in IDLE and FIN.
- Strobes are single-cycle and registered.
- mem_rd_en and mem_wr_en are never high together.
- alu_req is high only in CMP.
- start asserted while busy is ignored.
- Compare cost with alu_gnt tied high: 4 cycles without a swap, 6 cycles with a swap.
- count and base_addr changes during a sort have no effect.

Test Plan:
- [1,2,3,4] at base 0x100, count=4, alu_gnt=1 -> exactly one pass; 3 compares; no mem_wr_en; done 12 cycles after leaving IDLE; swap_count=0.
- [4,3,2,1], count=4 -> memory [1,2,3,4]; swap_count=6; done asserted exactly once; busy low the same cycle.
- [5,-3,0,-7,2], count=5 -> memory [-7,-3,0,2,5]; swap_count=6.
- count=1 and count=0 -> done one cycle after the start edge; no rd/wr strobes; busy stays 0.
- alu_gnt held low 5 cycles in the first CMP -> FSM stays in CMP; alu_req, alu_a, alu_b and alu_op unchanged; sort completes correctly after grant.
- reset asserted mid-WR0 on [4,3,2,1] -> same-cycle busy=0, mem_wr_en=0, swap_count=0; next start sorts correctly.
